// File: rtl/mem_arbiter.sv
// Shares one external memory port between I-side line refills and D-side line refills/writebacks.
// Each grant is a fixed LINE_WORDS burst, one beat per cycle, round-robin on conflict.
module mem_arbiter #(
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_rvalid,
    output logic        i_done,

    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_wready,
    output logic [31:0] d_rdata,
    output logic        d_rvalid,
    output logic        d_done,

    input  logic [31:0] MemData,
    output logic [31:0] MemAddr,
    output logic [31:0] MemWriteData,
    output logic        MemWe
);

    localparam int unsigned BEAT_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam int unsigned OFFS_W = $clog2(LINE_WORDS) + 2;
    localparam logic [31:0] OFFS_MASK = 32'((64'd1 << OFFS_W) - 64'd1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BURST = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    logic [1:0]        r_state;
    logic              r_owner;
    logic              r_we;
    logic [31:0]       r_base;
    logic [BEAT_W-1:0] r_beat;
    logic              r_last_grant;

    // Return-tracking pipeline: stage RD_LATENCY-1 lines up with MemData for the issued read.
    logic [RD_LATENCY-1:0] r_rv_pipe;
    logic [RD_LATENCY-1:0] r_own_pipe;
    logic [RD_LATENCY-1:0] r_last_pipe;

    logic [1:0]        w_state_nxt;
    logic              w_owner_nxt;
    logic              w_we_nxt;
    logic [31:0]       w_base_nxt;
    logic [BEAT_W-1:0] w_beat_nxt;
    logic              w_last_grant_nxt;

    logic w_grant_any;
    logic w_grant_d;
    logic w_in_burst;
    logic w_last_beat;
    logic w_wr_beat;
    logic w_rd_issue;
    logic w_ret_valid;
    logic w_ret_owner;
    logic w_ret_last;
    logic w_ret_done;

    assign w_grant_any = i_req | d_req;
    // D wins alone, or on a tie when I was the previous grantee.
    assign w_grant_d   = d_req & (~i_req | (r_last_grant == OWN_I));

    assign w_in_burst  = (r_state == ST_BURST);
    assign w_last_beat = (r_beat == LAST_BEAT);
    assign w_wr_beat   = w_in_burst & r_we;
    assign w_rd_issue  = w_in_burst & ~r_we;

    assign w_ret_valid = r_rv_pipe[RD_LATENCY-1];
    assign w_ret_owner = r_own_pipe[RD_LATENCY-1];
    assign w_ret_last  = r_last_pipe[RD_LATENCY-1];
    assign w_ret_done  = w_ret_valid & w_ret_last;

    always_comb begin
        w_state_nxt      = r_state;
        w_owner_nxt      = r_owner;
        w_we_nxt         = r_we;
        w_base_nxt       = r_base;
        w_beat_nxt       = r_beat;
        w_last_grant_nxt = r_last_grant;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_any) begin
                    w_owner_nxt      = w_grant_d ? OWN_D : OWN_I;
                    w_we_nxt         = w_grant_d & d_we;
                    w_base_nxt       = (w_grant_d ? d_addr : i_addr) & ~OFFS_MASK;
                    w_last_grant_nxt = w_owner_nxt;
                    w_beat_nxt       = '0;
                    w_state_nxt      = ST_BURST;
                end
            end
            ST_BURST: begin
                if (w_last_beat) begin
                    w_beat_nxt  = '0;
                    w_state_nxt = r_we ? ST_IDLE : ST_DRAIN;
                end else begin
                    w_beat_nxt = r_beat + BEAT_W'(1);
                end
            end
            ST_DRAIN: begin
                if (w_ret_done) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_owner      <= OWN_I;
            r_we         <= 1'b0;
            r_base       <= '0;
            r_beat       <= '0;
            r_last_grant <= OWN_I;
        end else begin
            r_state      <= w_state_nxt;
            r_owner      <= w_owner_nxt;
            r_we         <= w_we_nxt;
            r_base       <= w_base_nxt;
            r_beat       <= w_beat_nxt;
            r_last_grant <= w_last_grant_nxt;
        end
    end

    // Clearing the pipeline on reset drops any reads still in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rv_pipe   <= '0;
            r_own_pipe  <= '0;
            r_last_pipe <= '0;
        end else begin
            r_rv_pipe[0]   <= w_rd_issue;
            r_own_pipe[0]  <= r_owner;
            r_last_pipe[0] <= w_last_beat;
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_rv_pipe[i]   <= r_rv_pipe[i-1];
                r_own_pipe[i]  <= r_own_pipe[i-1];
                r_last_pipe[i] <= r_last_pipe[i-1];
            end
        end
    end

    assign MemAddr      = w_in_burst ? (r_base | (32'(r_beat) << 2)) : '0;
    assign MemWe        = w_wr_beat;
    assign MemWriteData = w_wr_beat ? d_wdata : '0;
    assign d_wready     = w_wr_beat;

    assign i_rdata  = MemData;
    assign d_rdata  = MemData;

    assign i_rvalid = w_ret_valid & (w_ret_owner == OWN_I);
    assign i_done   = i_rvalid & w_ret_last;
    assign d_rvalid = w_ret_valid & (w_ret_owner == OWN_D);
    assign d_done   = (w_wr_beat & w_last_beat) | (d_rvalid & w_ret_last);

endmodule
